// File: rtl/map_reader.sv
// Streams a snapshot of a square cell map out one cell per handshake, in row-major order.
// The cell outputs come straight from registers, so a stalled consumer always sees stable values.
module map_reader #(
   parameter  int unsigned map_width = 8,
   localparam int unsigned CW        = (map_width > 1) ? $clog2(map_width) : 1
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             start_i,
   input  logic                             abort_i,
   input  logic [map_width*map_width-1:0]   state_in_i,
   output logic                             cell_valid_o,
   input  logic                             cell_ready_i,
   output logic                             cell_alive_o,
   output logic [CW-1:0]                    cell_x_o,
   output logic [CW-1:0]                    cell_y_o,
   output logic                             cell_last_o,
   output logic                             busy_o,
   output logic                             done_o
);

   localparam int unsigned NCELL = map_width * map_width;
   localparam int unsigned IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NCELL - 1);
   localparam logic [CW-1:0] XMAX     = CW'(map_width - 1);

   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

   state_t           state_q;
   logic [NCELL-1:0] snap_q;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    x_q, x_d, y_q, y_d;
   logic             valid_q, alive_q, alive_d, last_q, last_d, busy_q, done_q;
   logic             xfer;

   assign xfer = valid_q && cell_ready_i;

   // Coordinates of the following cell, used when the current one is accepted.
   always_comb begin
      idx_d   = idx_q + 1'b1;
      x_d     = x_q + 1'b1;
      y_d     = y_q;
      if (x_q == XMAX) begin
         x_d = '0;
         y_d = y_q + 1'b1;
      end
      alive_d = snap_q[idx_d];
      last_d  = (idx_d == LAST_IDX);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         snap_q  <= '0;
         idx_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         alive_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  snap_q  <= state_in_i;
                  idx_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  valid_q <= 1'b1;
                  alive_q <= state_in_i[0];
                  last_q  <= (LAST_IDX == '0);
                  busy_q  <= 1'b1;
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               // Abort wins over a transfer in the same cycle.
               if (abort_i || (xfer && last_q)) begin
                  idx_q   <= '0;
                  x_q     <= '0;
                  y_q     <= '0;
                  valid_q <= 1'b0;
                  alive_q <= 1'b0;
                  last_q  <= 1'b0;
                  busy_q  <= !abort_i;
                  done_q  <= !abort_i;
                  state_q <= abort_i ? IDLE : DONE;
               end else if (xfer) begin
                  idx_q   <= idx_d;
                  x_q     <= x_d;
                  y_q     <= y_d;
                  alive_q <= alive_d;
                  last_q  <= last_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cell_valid_o = valid_q;
   assign cell_alive_o = alive_q;
   assign cell_x_o     = x_q;
   assign cell_y_o     = y_q;
   assign cell_last_o  = last_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_map_reader.sv
// Drives map_reader (map_width=4) with directed and random traffic and compares every cycle
// against a transaction-level model of the read-out.
module tb_map_reader;

   localparam int W = 4;
   localparam int N = W * W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          ready = 1'b0;
   logic [N-1:0]  state_in = '0;
   logic          valid, alive, last, busy, done;
   logic [1:0]    cx, cy;

   int n_pass = 0;
   int n_total = 0;

   map_reader #(.map_width(W)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
      .state_in_i(state_in), .cell_valid_o(valid), .cell_ready_i(ready),
      .cell_alive_o(alive), .cell_x_o(cx), .cell_y_o(cy), .cell_last_o(last),
      .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   // Reference: a captured map, the index of the cell on offer, and whether a done pulse is due.
   bit         m_active = 0;
   bit         m_done = 0;
   int         m_idx = 0;
   bit [N-1:0] m_snap = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active = 0; m_done = 0; m_idx = 0; m_snap = '0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_active) begin
         if (abort) begin
            m_active = 0; m_idx = 0;
         end else if (ready) begin
            $display("xfer cell (%0d,%0d) alive=%0d last=%0d", m_idx % W, m_idx / W,
                     m_snap[m_idx], m_idx == N - 1);
            if (m_idx == N - 1) begin
               m_active = 0; m_done = 1; m_idx = 0;
            end else begin
               m_idx++;
            end
         end
      end else if (start) begin
         m_snap = state_in; m_idx = 0; m_active = 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic check_all();
      chk("valid", 32'(valid), 32'(m_active));
      chk("alive", 32'(alive), m_active ? 32'(m_snap[m_idx]) : 32'd0);
      chk("x",     32'(cx),    m_active ? 32'(m_idx % W) : 32'd0);
      chk("y",     32'(cy),    m_active ? 32'(m_idx / W) : 32'd0);
      chk("last",  32'(last),  32'(m_active && m_idx == N - 1));
      chk("busy",  32'(busy),  32'(m_active || m_done));
      chk("done",  32'(done),  32'(m_done));
   endtask

   always @(negedge clk) check_all();

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cycles(2);
      rst_n = 1'b1;
      cycles(3);

      // Sparse map, full throughput.
      state_in = 16'h8001; ready = 1'b1; start = 1'b1;
      cycles(1); start = 1'b0;
      cycles(20);

      // Consumer accepts every other cycle.
      ready = 1'b0; start = 1'b1;
      cycles(1); start = 1'b0;
      repeat (40) begin ready = ~ready; cycles(1); end
      ready = 1'b1;
      cycles(3);

      // Input changes after capture must not leak into the stream.
      state_in = 16'h8001; start = 1'b1;
      cycles(1); start = 1'b0; state_in = 16'hFFFF;
      cycles(20);

      // Abort after five transfers, then restart.
      state_in = 16'h8001; start = 1'b1;
      cycles(1); start = 1'b0;
      cycles(5); abort = 1'b1;
      cycles(1); abort = 1'b0;
      cycles(2); start = 1'b1;
      cycles(1); start = 1'b0;
      cycles(20);

      // start held high: back-to-back streams.
      state_in = 16'h1234; start = 1'b1;
      cycles(40); start = 1'b0;
      cycles(3);

      // Asynchronous reset between edges mid-stream.
      state_in = 16'hFFFF; start = 1'b1;
      cycles(1); start = 1'b0;
      cycles(4);
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_busy",  32'(busy),  32'd0);
      chk("async_alive", 32'(alive), 32'd0);
      chk("async_xy",    32'({cx, cy}), 32'd0);
      cycles(2); rst_n = 1'b1;
      cycles(4);

      // Random traffic, including abort in DONE/IDLE and ready stalls.
      repeat (600) begin
         state_in = 16'($urandom);
         start    = ($urandom_range(0, 7) == 0);
         abort    = ($urandom_range(0, 40) == 0);
         ready    = ($urandom_range(0, 3) != 0);
         cycles(1);
      end
      start = 1'b0; abort = 1'b0; ready = 1'b1;
      cycles(25);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
